// File: rtl/vm2002_restock_if.sv
// Restock record bus and operator config/control signals for vm2002_restock_ctrl.
// master: the restock sequencer; slave: the operator/vm2002 side.
interface vm2002_restock_if;
    logic       cfg_we;
    logic [2:0] cfg_item;
    logic [3:0] cfg_count;
    logic [7:0] cfg_cost;
    logic       start;
    logic [7:0] mask;
    logic [2:0] item;
    logic [3:0] count;
    logic [7:0] cost;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] sent_cnt;
    logic       cfg_drop;

    modport master (
        input  cfg_we, cfg_item, cfg_count, cfg_cost, start, mask,
        output item, count, cost, valid, busy, done, sent_cnt, cfg_drop
    );

    modport slave (
        output cfg_we, cfg_item, cfg_count, cfg_cost, start, mask,
        input  item, count, cost, valid, busy, done, sent_cnt, cfg_drop
    );
endinterface

// File: rtl/vm2002_restock_ctrl.sv
// Supplier-side restock sequencer: walks a shadow stock table and emits one record per eligible slot.
// Optional macro RESTOCK_AUTOCLEAR_EN: a slot's enable bit clears once its record has been sent.
module vm2002_restock_ctrl #(
    parameter int NUM_ITEMS = 8,
    parameter int MAX_COUNT = 15,
    parameter int GAP       = 1
) (
    input logic              clk,
    input logic              rst,
    vm2002_restock_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_ITEMS - 1);
    localparam logic [3:0] MAX_CNT  = 4'(MAX_COUNT);
    localparam logic [7:0] GAP_LOAD = 8'((GAP > 0) ? (GAP - 1) : 0);

    state_t                 state_r;
    logic [2:0]             idx_r;
    logic [7:0]             mask_r;
    logic [7:0]             gap_cnt_r;
    logic [NUM_ITEMS-1:0]   en_r;
    logic [3:0]             tab_count_r [NUM_ITEMS];
    logic [7:0]             tab_cost_r  [NUM_ITEMS];

    logic [2:0]             item_r;
    logic [3:0]             count_r;
    logic [7:0]             cost_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   done_r;
    logic [3:0]             sent_cnt_r;
    logic                   cfg_drop_r;

    logic                   last_s;
    logic                   hit_s;

    function automatic logic [3:0] sat_count(input logic [3:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    // Scan-position decode shared by the state transitions.
    always_comb begin
        last_s = (idx_r == LAST_IDX);
        hit_s  = en_r[idx_r] & mask_r[idx_r];
    end

    // Table writes, run sequencing and all registered outputs; outputs are set on entry to a state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            idx_r      <= 3'd0;
            mask_r     <= 8'd0;
            gap_cnt_r  <= 8'd0;
            en_r       <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                tab_count_r[i] <= 4'd0;
                tab_cost_r[i]  <= 8'd0;
            end
            item_r     <= 3'd0;
            count_r    <= 4'd0;
            cost_r     <= 8'd0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sent_cnt_r <= 4'd0;
            cfg_drop_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            item_r  <= 3'd0;
            count_r <= 4'd0;
            cost_r  <= 8'd0;
            done_r  <= 1'b0;

            // The table is frozen while a run is in flight so a run sees one consistent snapshot.
            if (bus.cfg_we) begin
                if (busy_r) begin
                    cfg_drop_r <= 1'b1;
                end else begin
                    tab_count_r[bus.cfg_item] <= sat_count(bus.cfg_count);
                    tab_cost_r[bus.cfg_item]  <= bus.cfg_cost;
                    en_r[bus.cfg_item]        <= (bus.cfg_count != 4'd0);
                end
            end

            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_r     <= bus.mask;
                        sent_cnt_r <= 4'd0;
                        cfg_drop_r <= 1'b0;
                        idx_r      <= 3'd0;
                        if ((bus.mask & en_r) == 8'd0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= S_SCAN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (hit_s) begin
                        state_r    <= S_SEND;
                        valid_r    <= 1'b1;
                        item_r     <= idx_r;
                        count_r    <= tab_count_r[idx_r];
                        cost_r     <= tab_cost_r[idx_r];
                        sent_cnt_r <= sent_cnt_r + 4'd1;
                    end else if (last_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                S_SEND: begin
`ifdef RESTOCK_AUTOCLEAR_EN
                    en_r[idx_r] <= 1'b0;
`endif
                    if (GAP > 0) begin
                        state_r   <= S_GAP;
                        gap_cnt_r <= GAP_LOAD;
                    end else if (last_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_SCAN;
                        idx_r   <= idx_r + 3'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r != 8'd0) begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end else if (last_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_SCAN;
                        idx_r   <= idx_r + 3'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.item     = item_r;
    assign bus.count    = count_r;
    assign bus.cost     = cost_r;
    assign bus.valid    = valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sent_cnt = sent_cnt_r;
    assign bus.cfg_drop = cfg_drop_r;

endmodule

// File: tb/tb_vm2002_restock_ctrl.sv
// Scoreboard bench for vm2002_restock_ctrl: two instances (GAP=1 and GAP=0) share one stimulus stream
// and are checked against a table/arithmetic model of the restock run.
module tb_vm2002_restock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_item = 3'd0;
    logic [3:0] cfg_count = 4'd0;
    logic [7:0] cfg_cost = 8'd0;
    logic       start = 1'b0;
    logic [7:0] mask = 8'd0;

    always #5 clk = ~clk;

    vm2002_restock_if ifc0 ();
    vm2002_restock_if ifc1 ();

    assign ifc0.cfg_we = cfg_we;    assign ifc1.cfg_we = cfg_we;
    assign ifc0.cfg_item = cfg_item; assign ifc1.cfg_item = cfg_item;
    assign ifc0.cfg_count = cfg_count; assign ifc1.cfg_count = cfg_count;
    assign ifc0.cfg_cost = cfg_cost; assign ifc1.cfg_cost = cfg_cost;
    assign ifc0.start = start;      assign ifc1.start = start;
    assign ifc0.mask = mask;        assign ifc1.mask = mask;

    vm2002_restock_ctrl #(.NUM_ITEMS(8), .MAX_COUNT(15), .GAP(1)) u0 (.clk(clk), .rst(rst), .bus(ifc0.master));
    vm2002_restock_ctrl #(.NUM_ITEMS(8), .MAX_COUNT(15), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(ifc1.master));

    logic [2:0] o_item [2];
    logic [3:0] o_count [2];
    logic [7:0] o_cost [2];
    logic       o_valid [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic [3:0] o_sent [2];
    logic       o_drop [2];

    assign o_item[0] = ifc0.item;   assign o_item[1] = ifc1.item;
    assign o_count[0] = ifc0.count; assign o_count[1] = ifc1.count;
    assign o_cost[0] = ifc0.cost;   assign o_cost[1] = ifc1.cost;
    assign o_valid[0] = ifc0.valid; assign o_valid[1] = ifc1.valid;
    assign o_busy[0] = ifc0.busy;   assign o_busy[1] = ifc1.busy;
    assign o_done[0] = ifc0.done;   assign o_done[1] = ifc1.done;
    assign o_sent[0] = ifc0.sent_cnt; assign o_sent[1] = ifc1.sent_cnt;
    assign o_drop[0] = ifc0.cfg_drop; assign o_drop[1] = ifc1.cfg_drop;

    typedef struct { int item; int count; int cost; int t; } rec_t;
    typedef struct { int t; int sent; } dn_t;

    rec_t rq [2][$];
    dn_t  dq [2][$];
    int   mcnt [2][8];
    int   mcost [2][8];
    bit   men [2][8];
    bit   mdrop [2];
    int   bf [2];
    int   bt [2];
    int   cyc = 0;
    int   run_s = 0;
    int   ncmp = 0;
    int   nfail = 0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic bit in_win(input int k, input int c);
        return (c >= bf[k]) && (c <= bt[k]);
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s[u%0d] at cyc %0d: actual %0d required %0d", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rq[k].delete();
            dq[k].delete();
            mdrop[k] = 1'b0;
            bf[k] = 1;
            bt[k] = 0;
            for (int i = 0; i < 8; i++) begin
                mcnt[k][i] = 0;
                mcost[k][i] = 0;
                men[k][i] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        rec_t r;
        dn_t  d;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (o_valid[k]) begin
                if (rq[k].size() == 0) begin
                    chk("unexpected_valid", k, 1, 0);
                end else begin
                    r = rq[k].pop_front();
                    chk("rec_item", k, int'(o_item[k]), r.item);
                    chk("rec_count", k, int'(o_count[k]), r.count);
                    chk("rec_cost", k, int'(o_cost[k]), r.cost);
                    chk("rec_time", k, cyc, r.t);
                end
            end else begin
                chk("idle_bus_zero", k, int'({o_item[k], o_count[k], o_cost[k]}), 0);
            end
            if (o_done[k]) begin
                if (dq[k].size() == 0) begin
                    chk("unexpected_done", k, 1, 0);
                end else begin
                    d = dq[k].pop_front();
                    chk("done_time", k, cyc, d.t);
                    chk("done_sent_cnt", k, int'(o_sent[k]), d.sent);
                end
            end
            chk("busy", k, int'(o_busy[k]), int'(in_win(k, cyc)));
            chk("cfg_drop", k, int'(o_drop[k]), int'(mdrop[k]));
        end
    end

    task automatic cfg_write(input int it, input int cn, input int cs);
        bit drop [2];
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_item = 3'(it);
        cfg_count = 4'(cn);
        cfg_cost = 8'(cs);
        for (int k = 0; k < 2; k++) drop[k] = in_win(k, cyc);
        @(negedge clk);
        cfg_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (drop[k]) begin
                mdrop[k] = 1'b1;
            end else begin
                mcnt[k][it] = (cn > 15) ? 15 : cn;
                mcost[k][it] = cs;
                men[k][it] = (cn != 0);
            end
        end
    endtask

    task automatic do_start(input logic [7:0] m);
        int n;
        int td;
        rec_t r;
        dn_t  d;
        @(negedge clk);
        start = 1'b1;
        mask = m;
        run_s = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (men[k][i] && m[i]) begin
                    r.item = i;
                    r.count = mcnt[k][i];
                    r.cost = mcost[k][i];
                    r.t = run_s + i + 1 + n * (1 + gap_of(k));
                    rq[k].push_back(r);
                    n++;
`ifdef RESTOCK_AUTOCLEAR_EN
                    men[k][i] = 1'b0;
`endif
                end
            end
            td = (n == 0) ? 1 : 9 + n * (1 + gap_of(k));
            d.t = run_s + td - 1;
            d.sent = n;
            dq[k].push_back(d);
            bf[k] = run_s;
            bt[k] = run_s + td - 2;
        end
        @(negedge clk);
        start = 1'b0;
        mdrop[0] = 1'b0;
        mdrop[1] = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        int pend;
        pend = rq[0].size() + rq[1].size() + dq[0].size() + dq[1].size();
        while (pend != 0 && guard < 400) begin
            @(negedge clk);
            #2;
            guard++;
            pend = rq[0].size() + rq[1].size() + dq[0].size() + dq[1].size();
        end
        chk("run_completes", 0, pend, 0);
        for (int k = 0; k < 2; k++) begin
            rq[k].delete();
            dq[k].delete();
        end
    endtask

    task automatic run(input logic [7:0] m, input bit pulse, input bit wr, input int wi, input int wc, input int wcs);
        do_start(m);
        if (pulse) begin
            @(negedge clk);
            if (in_win(0, cyc) && in_win(1, cyc)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (wr) cfg_write(wi, wc, wcs);
        wait_idle();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset asserted between edges while u0 is in SEND.
        cfg_write(2, 5, 8'h20);
        cfg_write(5, 3, 8'h40);
        do_start(8'hFF);
        while (cyc < run_s + 3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 0, int'(ifc0.valid), 0);
        chk("rst_busy", 0, int'(ifc0.busy), 0);
        chk("rst_item", 0, int'(ifc0.item), 0);
        chk("rst_count", 0, int'(ifc0.count), 0);
        chk("rst_cost", 0, int'(ifc0.cost), 0);
        chk("rst_sent_cnt", 0, int'(ifc0.sent_cnt), 0);
        chk("rst_done", 0, int'(ifc0.done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run(8'hFF, 1'b0, 1'b0, 0, 0, 0);

        // Two-record run, repeated to exercise table persistence or autoclear.
        cfg_write(2, 5, 8'h20);
        cfg_write(5, 3, 8'h40);
        run(8'hFF, 1'b0, 1'b0, 0, 0, 0);
        run(8'hFF, 1'b0, 1'b0, 0, 0, 0);

        // Zero count disables a slot; mask selects only that slot.
        cfg_write(1, 0, 8'h11);
        cfg_write(3, 9, 8'h33);
        run(8'h02, 1'b0, 1'b0, 0, 0, 0);

        // Write during a run is dropped and flagged; next run clears the flag.
        cfg_write(6, 4, 8'h66);
        run(8'hFF, 1'b0, 1'b1, 4, 7, 8'h44);
        run(8'hFF, 1'b0, 1'b0, 0, 0, 0);

        // All slots full, start pulsed mid-run.
        for (int i = 0; i < 8; i++) cfg_write(i, 15, int'($urandom_range(0, 255)));
        run(8'hFF, 1'b1, 1'b0, 0, 0, 0);

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++)
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/vm2002_restock_ctrl.md
Name: vm2002_restock_ctrl

Overview:
Supplier-side sequencer that drives the vm2002 restocking interface (item, count, cost, valid). An operator programs a shadow stock table through a config port. On start, the block walks the table and emits one valid-qualified record per eligible slot, with a programmable idle gap between records. It sits between the supplier/operator logic and the vending machine core.

Parameters:
NUM_ITEMS, 8, table slots; the item code is the slot index, fixed at 8 to match the 3-bit item field.
MAX_COUNT, 15, saturation limit for a programmed count.
GAP, 1, idle cycles with valid=0 after each record; 0 is legal and means no gap.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
cfg_we  input  1  table write strobe
cfg_item  input  3  slot index to write
cfg_count  input  4  stock count to write
cfg_cost  input  8  unit cost to write
start  input  1  begin a restock run; level sampled in IDLE
mask  input  8  per-slot enable for the run; sampled with start
item  output  3  record slot index to vm2002
count  output  4  record count to vm2002
cost  output  8  record cost to vm2002
valid  output  1  record qualifier, 1-cycle pulse per record
busy  output  1  high from the cycle after start until DONE
done  output  1  1-cycle pulse at end of run
sent_cnt  output  4  records emitted in the current or last run
cfg_drop  output  1  sticky flag: a cfg write arrived while busy

Behaviour:
- Reset is asynchronous, active-high, on clk/rst:
  - item, count, cost, valid, busy, done, sent_cnt and cfg_drop all go to 0.
  - Every table entry is cleared (en=0, count=0, cost=0).
  - The FSM goes to IDLE and the scan index to 0.
  - Reset mid-run aborts the run immediately; no done pulse.
- Table entry contents: en bit, count[3:0], cost[7:0].
- cfg_we in IDLE/DONE (busy=0) writes slot cfg_item:
  - count = min(cfg_count, MAX_COUNT).
  - cost = cfg_cost.
  - en = (cfg_count != 0).
- cfg_we while busy=1: write is ignored and cfg_drop is set. cfg_drop clears on the next accepted start.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: start=1 latches mask, clears sent_cnt and cfg_drop, sets index=0, goes to SCAN. If (mask & en-vector)==0, go directly to DONE instead.
  - SCAN (1 cycle per index): if en[index] and mask[index], go to SEND. Otherwise, if index==7 go to DONE, else index+1 and stay in SCAN.
  - SEND (1 cycle): valid=1; item=index, count/cost from the table; sent_cnt+1.
    - If GAP>0, go to GAP.
    - If GAP==0: index==7 goes to DONE, else index+1 and SCAN.
  - GAP (GAP cycles, counter-driven): valid=0. Then index==7 goes to DONE, else index+1 and SCAN.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- busy=1 in SCAN, SEND and GAP; busy=0 in IDLE and DONE.
- item, count and cost are 0 whenever valid=0.
- start is ignored outside IDLE, including a start held high through DONE. Holding start high re-triggers a new run from IDLE on the cycle after DONE.
- sent_cnt holds its value after DONE until the next accepted start; maximum value is 8, no wrap.
- Table values are stable during a run because cfg writes are blocked while busy.

Optional Feature:
Macro RESTOCK_AUTOCLEAR_EN.
- Defined: in the SEND cycle, the sent slot's en bit clears (count and cost are retained). A repeated start with the same mask emits nothing and goes straight to DONE.
- Undefined: the table is persistent; every run re-sends all eligible slots.

Test Plan:
1. Reset mid-SEND (rst asserted between edges) -> all outputs 0 immediately, no done pulse; a following start with mask=FF goes straight to DONE with sent_cnt=0.
2. GAP=1; program slot2 (count=5, cost=0x20) and slot5 (count=3, cost=0x40); start at T0, mask=FF -> valid at T4 (item=2, count=5, cost=0x20) and T9 (item=5, count=3, cost=0x40); done at T13; sent_cnt=2; busy high T1..T12.
3. Program slot1 with cfg_count=0 and slot3 with count=9; start with mask=0x02 -> DONE at T1, done pulse, no valid, sent_cnt=0.
4. cfg_we to slot4 during a run -> write ignored, cfg_drop=1; slot4 is absent from the next run; cfg_drop=0 after that start.
5. GAP=0; all 8 slots enabled with count=15 -> 8 valid pulses, each preceded by one SCAN cycle; sent_cnt=8; a start pulse held during the run is ignored.
6. RESTOCK_AUTOCLEAR_EN defined; scenario 2 run twice -> second run yields 0 valid and sent_cnt=0. With the macro undefined, the second run yields 2 valid pulses again.
